// File: rtl/data_mem_responder_if.sv
// Bus interface for data_mem_responder.
// Carries the core DRAM port (mem_addr/mem_wdata/mem_rdata/memREAD/memWRITE),
// the host command channel (host_cmd_*), the host load stream (host_w*), the
// host dump stream (host_r*) and status (core_en, busy, done, err).
// slave  : the responder side.
// master : the core/host side that drives requests.
interface data_mem_responder_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  memREAD;
  logic                  memWRITE;
  logic                  host_cmd_valid;
  logic                  host_cmd_op;
  logic [ADDR_WIDTH-1:0] host_cmd_base;
  logic [ADDR_WIDTH-1:0] host_cmd_len;
  logic                  host_cmd_ready;
  logic [WIDTH-1:0]      host_wdata;
  logic                  host_wvalid;
  logic                  host_wready;
  logic [WIDTH-1:0]      host_rdata;
  logic                  host_rvalid;
  logic                  host_rready;
  logic                  core_en;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  mem_addr, mem_wdata, memREAD, memWRITE,
    input  host_cmd_valid, host_cmd_op, host_cmd_base, host_cmd_len,
    input  host_wdata, host_wvalid, host_rready,
    output mem_rdata, host_cmd_ready, host_wready, host_rdata, host_rvalid,
    output core_en, busy, done, err
  );

  modport master (
    output mem_addr, mem_wdata, memREAD, memWRITE,
    output host_cmd_valid, host_cmd_op, host_cmd_base, host_cmd_len,
    output host_wdata, host_wvalid, host_rready,
    input  mem_rdata, host_cmd_ready, host_wready, host_rdata, host_rvalid,
    input  core_en, busy, done, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder on the far side of the core's DRAM interface.
// Serves core memREAD/memWRITE accesses to a DEPTH-word array while idle, and
// runs host-side streaming load (host -> array) and dump (array -> host)
// transfers. Core access and host streaming are mutually exclusive; core_en
// reports when the core may run.
// Ports:
//   Clk   : clock, all state updates on the rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : data_mem_responder_if slave modport (core port, host command,
//           load stream, dump stream, status)
module data_mem_responder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  data_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  logic [WIDTH-1:0]      mem_array [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      mem_rdata_q, mem_rdata_d;
  logic [WIDTH-1:0]      host_rdata_q, host_rdata_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic                  err_q, err_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  dump_consume;
  logic                  dump_issue;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    mem_rdata_d   = mem_rdata_q;
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = host_rvalid_q;
    mem_we        = 1'b0;
    mem_waddr     = addr_q;
    mem_wdata     = bus.host_wdata;
    dump_consume  = host_rvalid_q && bus.host_rready;
    dump_issue    = 1'b0;

    // Core strobes outside IDLE are dropped and latch the error flag.
    err_d = err_q || ((state_q != S_IDLE) && (bus.memREAD || bus.memWRITE));

    unique case (state_q)
      S_IDLE: begin
        // Array read is taken before the write lands, so a simultaneous
        // read/write returns the old contents.
        if (bus.memWRITE) begin
          mem_we    = 1'b1;
          mem_waddr = bus.mem_addr;
          mem_wdata = bus.mem_wdata;
        end
        if (bus.memREAD) begin
          mem_rdata_d = mem_array[bus.mem_addr];
        end
        if (bus.host_cmd_valid) begin
          addr_d = bus.host_cmd_base;
          cnt_d  = bus.host_cmd_len;
          if (bus.host_cmd_len == '0) begin
            state_d = S_DONE;
          end else if (bus.host_cmd_op) begin
            state_d = S_DUMP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (bus.host_wvalid) begin
          mem_we = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - ADDR_WIDTH'(1);
          if (cnt_q == ADDR_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DUMP: begin
        // One-entry output register: refill when empty or draining this cycle.
        dump_issue = (!host_rvalid_q || dump_consume) && (cnt_q != '0);
        if (dump_issue) begin
          host_rdata_d  = mem_array[addr_q];
          host_rvalid_d = 1'b1;
          addr_d        = addr_q + ADDR_WIDTH'(1);
          cnt_d         = cnt_q - ADDR_WIDTH'(1);
        end else if (dump_consume) begin
          host_rvalid_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      mem_rdata_q   <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      mem_rdata_q   <= mem_rdata_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      err_q         <= err_d;
    end
  end

  // Array contents survive reset; writes are suppressed while reset is held.
  always_ff @(posedge Clk) begin
    if (mem_we && Rst_n) begin
      mem_array[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.mem_rdata      = mem_rdata_q;
  assign bus.host_rdata     = host_rdata_q;
  assign bus.host_rvalid    = host_rvalid_q;
  assign bus.err            = err_q;
  assign bus.core_en        = (state_q == S_IDLE);
  assign bus.host_cmd_ready = (state_q == S_IDLE);
  assign bus.host_wready    = (state_q == S_LOAD);
  assign bus.busy           = (state_q == S_LOAD) || (state_q == S_DUMP);
  assign bus.done           = (state_q == S_DONE);

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  data_mem_responder_if #(.WIDTH(8), .ADDR_WIDTH(8)) bus ();

  data_mem_responder #(.WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned done_cnt = 0;
  logic [7:0]  core_exp [$];
  logic [7:0]  dump_exp [$];
  logic        rd_pend = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic core_write(input logic [7:0] a, input logic [7:0] d);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.memWRITE  = 1'b1;
    tick();
    bus.memWRITE  = 1'b0;
  endtask

  task automatic core_read(input logic [7:0] a, input logic [7:0] exp);
    bus.mem_addr = a;
    bus.memREAD  = 1'b1;
    core_exp.push_back(exp);
    tick();
    bus.memREAD  = 1'b0;
  endtask

  task automatic issue_cmd(input logic op, input logic [7:0] base, input logic [7:0] len);
    bus.host_cmd_op    = op;
    bus.host_cmd_base  = base;
    bus.host_cmd_len   = len;
    bus.host_cmd_valid = 1'b1;
    check("cmd_ready", 16'(bus.host_cmd_ready), 16'd1);
    tick();
    bus.host_cmd_valid = 1'b0;
  endtask

  // Drain the dump scoreboard with rready held high, bounded.
  task automatic drain_dump(input string name);
    int unsigned n;
    n = 0;
    bus.host_rready = 1'b1;
    while (dump_exp.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 16'(dump_exp.size()), 16'd0);
    check({name, "_done"}, 16'(bus.done), 16'd1);
    bus.host_rready = 1'b0;
  endtask

  initial begin
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.memREAD = 1'b0; bus.memWRITE = 1'b0;
    bus.host_cmd_valid = 1'b0; bus.host_cmd_op = 1'b0;
    bus.host_cmd_base = '0; bus.host_cmd_len = '0;
    bus.host_wdata = '0; bus.host_wvalid = 1'b0; bus.host_rready = 1'b0;

    fork
      // Monitor: compares whatever the DUT presents against the scoreboards.
      begin
        forever begin
          @(negedge Clk);
          if (bus.done === 1'b1) done_cnt++;
          if (rd_pend) begin
            if (core_exp.size() == 0) check("core_rd_unexpected", 16'(bus.mem_rdata), 16'hFFFF);
            else check("core_rdata", 16'(bus.mem_rdata), 16'(core_exp.pop_front()));
          end
          rd_pend = bus.memREAD && bus.core_en && Rst_n;
          if (bus.host_rvalid === 1'b1) begin
            if (dump_exp.size() == 0) check("dump_unexpected", 16'(bus.host_rdata), 16'hFFFF);
            else begin
              check("dump_rdata", 16'(bus.host_rdata), 16'(dump_exp[0]));
              if (bus.host_rready) void'(dump_exp.pop_front());
            end
          end
        end
      end

      begin
        int unsigned d0;
        logic [0:5] rpat;
        // Reset state
        #3;
        check("rst_mem_rdata", 16'(bus.mem_rdata), 16'h0);
        check("rst_host_rdata", 16'(bus.host_rdata), 16'h0);
        check("rst_rvalid", 16'(bus.host_rvalid), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_err", 16'(bus.err), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_core_en", 16'(bus.core_en), 16'd1);
        check("rst_cmd_ready", 16'(bus.host_cmd_ready), 16'd1);
        #9 Rst_n = 1'b1;
        tick();

        // Core write then read, value held afterwards
        core_write(8'h10, 8'hA5);
        core_read(8'h10, 8'hA5);
        tick();
        check("rdata_hold1", 16'(bus.mem_rdata), 16'hA5);
        tick();
        check("rdata_hold2", 16'(bus.mem_rdata), 16'hA5);

        // Read-first on simultaneous read/write
        core_write(8'h20, 8'h11);
        bus.mem_wdata = 8'h22;
        bus.memWRITE  = 1'b1;
        core_read(8'h20, 8'h11);
        bus.memWRITE  = 1'b0;
        core_read(8'h20, 8'h22);

        // Load with address wrap and one wvalid bubble
        d0 = done_cnt;
        issue_cmd(1'b0, 8'hFE, 8'd3);
        check("load_core_en", 16'(bus.core_en), 16'd0);
        check("load_busy", 16'(bus.busy), 16'd1);
        check("load_wready", 16'(bus.host_wready), 16'd1);
        bus.host_wdata = 8'h01; bus.host_wvalid = 1'b1; tick();
        bus.host_wvalid = 1'b0; tick();
        check("load_core_en_bubble", 16'(bus.core_en), 16'd0);
        bus.host_wdata = 8'h02; bus.host_wvalid = 1'b1; tick();
        bus.host_wdata = 8'h03; tick();
        bus.host_wvalid = 1'b0;
        check("load_done", 16'(bus.done), 16'd1);
        check("load_done_busy", 16'(bus.busy), 16'd0);
        tick();
        check("load_done_clear", 16'(bus.done), 16'd0);
        check("load_core_en_back", 16'(bus.core_en), 16'd1);
        check("load_done_count", 16'(done_cnt - d0), 16'd1);
        core_read(8'hFE, 8'h01);
        core_read(8'hFF, 8'h02);
        core_read(8'h00, 8'h03);

        // Dump with backpressure
        for (int i = 0; i < 4; i++) core_write(8'(4 + i), 8'(8'h40 + i));
        for (int i = 0; i < 4; i++) dump_exp.push_back(8'(8'h40 + i));
        d0 = done_cnt;
        issue_cmd(1'b1, 8'h04, 8'd4);
        rpat = 6'b100111;
        for (int i = 0; i < 6; i++) begin
          bus.host_rready = rpat[i];
          tick();
        end
        drain_dump("dump");
        tick();
        check("dump_done_count", 16'(done_cnt - d0), 16'd1);

        // Lockout and sticky err
        check("err_before", 16'(bus.err), 16'd0);
        core_write(8'h30, 8'h33);
        issue_cmd(1'b0, 8'h50, 8'd2);
        bus.mem_addr = 8'h30; bus.mem_wdata = 8'hFF;
        bus.memWRITE = 1'b1; bus.memREAD = 1'b1;
        tick();
        bus.memWRITE = 1'b0; bus.memREAD = 1'b0;
        check("err_set", 16'(bus.err), 16'd1);
        check("lockout_rdata", 16'(bus.mem_rdata), 16'h03);
        bus.host_wdata = 8'h61; bus.host_wvalid = 1'b1; tick();
        bus.host_wdata = 8'h62; tick();
        bus.host_wvalid = 1'b0;
        tick();
        check("err_sticky", 16'(bus.err), 16'd1);
        check("idle_core_en", 16'(bus.core_en), 16'd1);
        core_read(8'h30, 8'h33);
        core_read(8'h50, 8'h61);
        core_read(8'h51, 8'h62);

        // Zero-length command
        bus.host_wdata = 8'hEE; bus.host_wvalid = 1'b1;
        issue_cmd(1'b0, 8'h50, 8'd0);
        check("len0_done", 16'(bus.done), 16'd1);
        bus.host_wvalid = 1'b0;
        tick();
        check("len0_done_clear", 16'(bus.done), 16'd0);
        core_read(8'h50, 8'h61);

        // Async reset mid-dump
        dump_exp.push_back(8'h40);
        issue_cmd(1'b1, 8'h04, 8'd4);
        tick();
        check("pre_rst_rvalid", 16'(bus.host_rvalid), 16'd1);
        #2 Rst_n = 1'b0;
        #1;
        check("arst_rvalid", 16'(bus.host_rvalid), 16'd0);
        check("arst_busy", 16'(bus.busy), 16'd0);
        check("arst_core_en", 16'(bus.core_en), 16'd1);
        check("arst_err", 16'(bus.err), 16'd0);
        dump_exp.delete();
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        core_read(8'h04, 8'h40);
        dump_exp.push_back(8'h42);
        issue_cmd(1'b1, 8'h06, 8'd1);
        drain_dump("post_rst_dump");
        tick();
        tick();
        check("core_q_empty", 16'(core_exp.size()), 16'd0);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder that sits on the far side of the core's DRAM interface.
- Services the core's memREAD/memWRITE accesses to a DEPTH-word internal array.
- Also provides a host-side streaming load/dump engine, used to preload operand matrices and read back results around a core run.
- Host streaming and core access are mutually exclusive; core_en tells the top level when the core may run.

Parameters:
WIDTH, 8, data word width (matches core WIDTH)
ADDR_WIDTH, 8, address width
DEPTH, 256, number of words; must equal 2**ADDR_WIDTH

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst_n  input  1  asynchronous active-low reset
mem_addr  input  ADDR_WIDTH  core DRAM_addr
mem_wdata  input  WIDTH  core DRAM_dataOut
mem_rdata  output  WIDTH  to core DRAM_dataIn
memREAD  input  1  core read strobe
memWRITE  input  1  core write strobe
host_cmd_valid  input  1  host command request
host_cmd_op  input  1  0 = load, 1 = dump
host_cmd_base  input  ADDR_WIDTH  start address
host_cmd_len  input  ADDR_WIDTH  word count; 0 = no transfer
host_cmd_ready  output  1  command accepted when valid&&ready
host_wdata  input  WIDTH  load data
host_wvalid  input  1  load data valid
host_wready  output  1  load data accepted
host_rdata  output  WIDTH  dump data
host_rvalid  output  1  dump data valid
host_rready  input  1  dump data consumed
core_en  output  1  core accesses serviced
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at transfer end
err  output  1  sticky: core access while not core_en

Behaviour:
- Reset (async, Rst_n=0):
  - FSM goes to IDLE.
  - mem_rdata, host_rdata, host_rvalid, done, err, busy = 0; core_en = 1; host_cmd_ready = 1.
  - Array contents are not reset.
- FSM states: IDLE, LOAD, DUMP, DONE.
- IDLE (core_en=1, host_cmd_ready=1, busy=0):
  - memWRITE at an edge writes mem[mem_addr] <= mem_wdata.
  - memREAD at an edge loads mem_rdata <= mem[mem_addr], giving 1-cycle latency.
  - mem_rdata holds its value until the next memREAD.
  - memREAD and memWRITE in the same cycle: the write is performed and mem_rdata returns the OLD contents (read-first).
- Command acceptance, in IDLE:
  - host_cmd_valid latches base into the address counter and len into the remaining-count register.
  - len=0 goes directly to DONE.
  - Otherwise op=0 goes to LOAD and op=1 goes to DUMP.
- LOAD (core_en=0, busy=1, host_wready=1):
  - Each host_wvalid beat writes mem[addr] <= host_wdata, then addr+1 and count-1.
  - The beat with count==1 goes to DONE.
- DUMP (core_en=0, busy=1):
  - One-entry output register.
  - A read issues when the register is empty or is being consumed (host_rvalid && host_rready) and count>0. Data appears the next cycle with host_rvalid=1.
  - Full throughput is one word per cycle when host_rready stays high.
  - host_rdata is stable while host_rvalid && !host_rready.
  - The state goes to DONE when count==0 and the last word has been consumed.
- DONE: done=1 for exactly one cycle, then IDLE; busy=0; core_en returns to 1 in IDLE.
- Address counter wraps modulo DEPTH (e.g. 0xFF+1 -> 0x00).
- Core strobes while core_en=0:
  - Ignored: no array write and mem_rdata unchanged.
  - err set to 1 and held until reset.
- host_cmd_valid outside IDLE is ignored (host_cmd_ready=0).
- Reset during LOAD/DUMP aborts immediately. Array words already written stay written; the rest are untouched.

Test Plan:
- Core access: memWRITE addr 0x10 data 0xA5; next cycle memREAD 0x10 -> mem_rdata=0xA5 one edge later and held through two idle cycles.
- Read-first: mem[0x20]=0x11; memREAD+memWRITE 0x20 data 0x22 together -> mem_rdata=0x11; a later read returns 0x22.
- Load with wrap: cmd op=0 base=0xFE len=3, data 0x01,0x02,0x03 with one wvalid bubble -> mem[0xFE]=0x01, mem[0xFF]=0x02, mem[0x00]=0x03; done pulses once; core_en=0 throughout the transfer.
- Dump with backpressure: preload mem[4..7]=0x40..0x43; cmd op=1 base=4 len=4; rready pattern 1,0,0,1,1,1 -> sequence 0x40..0x43 in order, no duplicates or drops, rdata stable during stalls; done after the 4th accepted beat.
- Lockout/err: during LOAD pulse memWRITE addr 0x30 data 0xFF -> mem[0x30] unchanged and err=1, still 1 after return to IDLE; len=0 command -> done pulse the cycle after acceptance with no array change.
- Async reset mid-DUMP: drop Rst_n between clock edges -> host_rvalid=0, busy=0, core_en=1 immediately; the next command is accepted normally.
